odd_parity_serial_tx: RTL and testbench
=======================================

Name: odd_parity_serial_tx

Overview:
- Transmit side of the 4-bit odd-parity link whose receive side is odd_parity_checker (inputs a, b, c, d, p; output pec).
- Accepts a 4-bit nibble over a valid/ready handshake and computes odd parity p, so that a^b^c^d^p = 1.
- Serialises the nibble into a fixed 7-bit frame at a parameterised bit rate, for a downstream deserialiser feeding the checker.
- Also presents the latched nibble and parity in parallel, so the checker can be driven directly.

Parameters:
- CLKS_PER_BIT, 4, clock cycles each frame bit is held on tx; legal range 1..1024.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  nibble available
- in_data  in  4  nibble; in_data[3]=a, [2]=b, [1]=c, [0]=d
- in_ready  out  1  block can accept a nibble this cycle
- tx  out  1  serial line; idles at 1
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse when a frame completes
- par_a, par_b, par_c, par_d  out  1 each  latched nibble bits
- par_p  out  1  latched odd parity bit

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx=1, busy=0, done=0, in_ready=1.
  - par_a..par_d=0, par_p=1 (odd parity of 0000).
  - FSM returns to IDLE; any partial frame is abandoned, with no done pulse.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - in_ready=1, tx=1.
  - Acceptance occurs when in_valid && in_ready at a clock edge.
  - On that edge: latch the nibble and parity into par_*, go to START, drive tx=0, set busy=1, clear in_ready.
- Bit timer:
  - Counter width clog2(CLKS_PER_BIT), minimum 1 bit.
  - Each frame bit is held exactly CLKS_PER_BIT cycles.
  - The counter wraps to 0 on every bit boundary.
  - With CLKS_PER_BIT=1 the state advances every cycle.
- Frame order on tx:
  - start bit (0), then a, b, c, d (MSB first), then p, then stop bit (1).
  - 7 bits total, 7*CLKS_PER_BIT cycles from the accept edge to the end of the stop bit.
- DATA: a 2-bit index selects the bit (0..3); leave DATA after index 3 completes.
- PARITY: tx=par_p.
- STOP:
  - tx=1.
  - On the final cycle of the stop bit: go to IDLE, clear busy, set in_ready, and pulse done=1 for exactly one cycle. done coincides with the first IDLE cycle.
- Back-to-back frames:
  - A nibble presented while done=1 is accepted at that edge.
  - The next start bit follows the previous stop bit with zero extra idle cycles.
- While busy: in_valid is ignored, in_data changes have no effect, and par_* stay stable.
- Parity rule: p = ~(a^b^c^d).

Decomposition:
- Package odd_parity_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - FRAME_BITS=7
  - NIBBLE_W=4
  - the idle line level constant (1)
- One combinational sub-module, odd_parity_gen: in 4 bits → p.
  - Reusable by the checker side for a reference computation.

Test Plan:
- Reset: assert rst_n=0 mid-frame → tx=1, busy=0, in_ready=1, par_p=1 on the same cycle, with no done pulse.
- Exhaustive parity: accept all 16 nibbles (CLKS_PER_BIT=1) → par_p=1 for 0000, 0 for 0001, 1 for 1111, 0 for 0111. Every {par_a..par_d, par_p} fed to odd_parity_checker gives pec=no-error.
- Frame timing: CLKS_PER_BIT=4, in_data=4'b1010 → tx sequence 0,1,0,1,0,1(p),1(stop), each bit held 4 cycles. done pulses 28 cycles after the accept edge.
- Busy ignore: present 4'b0011 mid-frame with in_valid=1 → not accepted, par_* unchanged, in_ready stays 0 until done.
- Back-to-back: hold in_valid=1 with 4'b0000, then 4'b1111 → second start bit directly follows the first stop bit. Parity bits are 1 and 1.
- CLKS_PER_BIT=1 edge case: frame completes in exactly 7 cycles and done pulses once.

Source files
------------

// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity serial link (transmit side and checker side).
//   state_e    : transmitter FSM states
//   FRAME_BITS : bits per serial frame (start, a, b, c, d, p, stop)
//   NIBBLE_W   : payload width
//   IDLE_LEVEL : level of the serial line between frames
package odd_parity_pkg;

    localparam int unsigned FRAME_BITS = 7;
    localparam int unsigned NIBBLE_W   = 4;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

endpackage : odd_parity_pkg

// File: rtl/odd_parity_serial_tx_if.sv
// Bundles the nibble handshake, the serial line, the status flags and the parallel
// (checker-facing) outputs of odd_parity_serial_tx.
//   master : drives in_valid/in_data, observes everything else (producer / bench)
//   slave  : the transmitter itself
interface odd_parity_serial_tx_if;
    import odd_parity_pkg::*;

    logic                in_valid;
    logic [NIBBLE_W-1:0] in_data;   // [3]=a, [2]=b, [1]=c, [0]=d
    logic                in_ready;
    logic                tx;
    logic                busy;
    logic                done;
    logic                par_a;
    logic                par_b;
    logic                par_c;
    logic                par_d;
    logic                par_p;

    modport master (
        output in_valid, in_data,
        input  in_ready, tx, busy, done, par_a, par_b, par_c, par_d, par_p
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, tx, busy, done, par_a, par_b, par_c, par_d, par_p
    );

endinterface : odd_parity_serial_tx_if

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator: parity_o makes the XOR of data_i and parity_o equal 1.
//   data_i   : nibble {a, b, c, d}
//   parity_o : odd parity bit p = ~(a ^ b ^ c ^ d)
module odd_parity_gen
    import odd_parity_pkg::*;
(
    input  logic [NIBBLE_W-1:0] data_i,
    output logic                parity_o
);

    always_comb begin
        parity_o = ~(^data_i);
    end

endmodule : odd_parity_gen

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter. Accepts a nibble on a valid/ready handshake, latches it
// with its odd parity bit onto the parallel outputs, and shifts out a 7-bit frame
// (start 0, a, b, c, d, p, stop 1), each bit held CLKS_PER_BIT cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of odd_parity_serial_tx_if (handshake, tx, busy, done, par_*)
// CLKS_PER_BIT legal range is 1..1024.
module odd_parity_serial_tx
    import odd_parity_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    odd_parity_serial_tx_if.slave  bus
);

    localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [1:0]          idx_q;
    logic [NIBBLE_W-1:0] nib_q;
    logic                p_q;
    logic                tx_q;
    logic                busy_q;
    logic                done_q;
    logic                ready_q;

    logic                p_gen;
    logic                bit_last;
    logic [1:0]          idx_d;
    logic                data_bit_d;
    logic [CntW-1:0]     cnt_d;

    odd_parity_gen u_gen (
        .data_i   (bus.in_data),
        .parity_o (p_gen)
    );

    always_comb begin
        bit_last   = (cnt_q == CntLast);
        // Timer wraps to 0 on every bit boundary.
        cnt_d      = bit_last ? '0 : cnt_q + CntW'(1);
        idx_d      = idx_q + 2'd1;
        // MSB first: index i selects nib_q[3-i], which for a 2-bit index is nib_q[~i].
        data_bit_d = nib_q[~idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            nib_q   <= '0;
            p_q     <= 1'b1;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx_q <= IDLE_LEVEL;
                    if (bus.in_valid && ready_q) begin
                        nib_q   <= bus.in_data;
                        p_q     <= p_gen;
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    cnt_q <= cnt_d;
                    if (bit_last) begin
                        state_q <= StData;
                        idx_q   <= '0;
                        tx_q    <= nib_q[NIBBLE_W-1];
                    end
                end
                StData: begin
                    cnt_q <= cnt_d;
                    if (bit_last) begin
                        if (idx_q == 2'd3) begin
                            state_q <= StParity;
                            tx_q    <= p_q;
                        end else begin
                            idx_q <= idx_d;
                            tx_q  <= data_bit_d;
                        end
                    end
                end
                StParity: begin
                    cnt_q <= cnt_d;
                    if (bit_last) begin
                        state_q <= StStop;
                        tx_q    <= IDLE_LEVEL;
                    end
                end
                StStop: begin
                    cnt_q <= cnt_d;
                    // Leaving on the last stop cycle makes the done cycle the first IDLE
                    // cycle; a nibble offered then starts the next frame at that edge.
                    if (bit_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.par_a    = nib_q[3];
    assign bus.par_b    = nib_q[2];
    assign bus.par_c    = nib_q[1];
    assign bus.par_d    = nib_q[0];
    assign bus.par_p    = p_q;

endmodule : odd_parity_serial_tx

// File: tb/tb_odd_parity_serial_tx.sv
// Bench for odd_parity_serial_tx: one instance at CLKS_PER_BIT=4 (serial framing, busy
// behaviour, back-to-back, mid-frame reset) and one at CLKS_PER_BIT=1 (exhaustive parity,
// minimum frame length). Expected frames go into per-instance queues when a nibble is
// offered; monitors pop and compare when done pulses.
module tb_odd_parity_serial_tx;
    import odd_parity_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    odd_parity_serial_tx_if bus4 ();
    odd_parity_serial_tx_if bus1 ();

    odd_parity_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    odd_parity_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [NIBBLE_W-1:0] q4 [$];
    logic [NIBBLE_W-1:0] q1 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Odd parity: p=1 when the nibble holds an even number of ones.
    function automatic logic exp_par(input logic [3:0] n);
        return ($countones(n) % 2) == 0;
    endfunction

    function automatic logic [FRAME_BITS-1:0] exp_frame(input logic [3:0] n);
        return {1'b0, n, exp_par(n), 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [3:0] n);
        for (int i = 0; i < 100 && bus4.in_ready !== 1'b1; i++) tick();
        check("rdy4_wait", bus4.in_ready, 1);
        bus4.in_valid = 1'b1;
        bus4.in_data  = n;
        q4.push_back(n);
        tick();
        bus4.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [3:0] n);
        for (int i = 0; i < 50 && bus1.in_ready !== 1'b1; i++) tick();
        check("rdy1_wait", bus1.in_ready, 1);
        bus1.in_valid = 1'b1;
        bus1.in_data  = n;
        q1.push_back(n);
        tick();
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_done4(input string tag);
        for (int i = 0; i < 100 && bus4.done !== 1'b1; i++) tick();
        check(tag, bus4.done, 1);
    endtask

    // Serial monitor, CLKS_PER_BIT=4: sample mid-bit, expect done 28 cycles after accept.
    initial begin : mon4
        int cyc;
        logic [FRAME_BITS-1:0] bits;
        bit act;
        act = 1'b0;
        cyc = 0;
        bits = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                act = 1'b0;
                continue;
            end
            if (!act && bus4.busy === 1'b1 && bus4.tx === 1'b0) begin
                act = 1'b1;
                cyc = 0;
                bits = '0;
            end
            if (act) begin
                if (bus4.done === 1'b1) begin
                    check("frame_len4", cyc, 28);
                    check("sb4_depth", (q4.size() > 0), 1);
                    if (q4.size() > 0) check("frame4", bits, exp_frame(q4.pop_front()));
                    act = 1'b0;
                end else begin
                    if (cyc % 4 == 2) bits = {bits[FRAME_BITS-2:0], bus4.tx};
                    cyc++;
                end
            end else begin
                check("stray_done4", bus4.done, 0);
                check("idle_tx4", bus4.tx, 1);
            end
        end
    end

    // Serial + parallel monitor, CLKS_PER_BIT=1: 7-cycle frame, parity seen by checker model.
    initial begin : mon1
        int cyc;
        logic [FRAME_BITS-1:0] bits;
        logic [3:0] n;
        bit act;
        act = 1'b0;
        cyc = 0;
        bits = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                act = 1'b0;
                continue;
            end
            if (!act && bus1.busy === 1'b1 && bus1.tx === 1'b0) begin
                act = 1'b1;
                cyc = 0;
                bits = '0;
            end
            if (act) begin
                if (bus1.done === 1'b1) begin
                    check("frame_len1", cyc, 7);
                    check("sb1_depth", (q1.size() > 0), 1);
                    if (q1.size() > 0) begin
                        n = q1.pop_front();
                        check("frame1", bits, exp_frame(n));
                        check("par1", {bus1.par_a, bus1.par_b, bus1.par_c, bus1.par_d,
                                       bus1.par_p}, {n, exp_par(n)});
                        // Checker reports no error when a^b^c^d^p == 1.
                        check("pec1", bus1.par_a ^ bus1.par_b ^ bus1.par_c ^ bus1.par_d
                                      ^ bus1.par_p, 1);
                    end
                    act = 1'b0;
                end else begin
                    bits = {bits[FRAME_BITS-2:0], bus1.tx};
                    cyc++;
                end
            end else begin
                check("stray_done1", bus1.done, 0);
            end
        end
    end

    initial begin : stim
        logic [4:0] ptab [4];
        logic [4:0] held;
        ptab[0] = 5'b0000_1;
        ptab[1] = 5'b0001_0;
        ptab[2] = 5'b1111_1;
        ptab[3] = 5'b0111_0;

        rst_n = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.in_data  = '0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        tick();
        tick();
        check("rst_tx", bus4.tx, 1);
        check("rst_busy", bus4.busy, 0);
        check("rst_done", bus4.done, 0);
        check("rst_ready", bus4.in_ready, 1);
        check("rst_par", {bus4.par_a, bus4.par_b, bus4.par_c, bus4.par_d, bus4.par_p}, 5'b00001);
        check("rst_par1", {bus1.par_a, bus1.par_b, bus1.par_c, bus1.par_d, bus1.par_p},
              5'b00001);
        rst_n = 1'b1;
        tick();

        // Parity table at CLKS_PER_BIT=1, then all 16 nibbles.
        for (int i = 0; i < 4; i++) begin
            send1(ptab[i][4:1]);
            check("par_tab", bus1.par_p, ptab[i][0]);
        end
        for (int n = 0; n < 16; n++) begin
            send1(4'(n));
            check("par_all", {bus1.par_a, bus1.par_b, bus1.par_c, bus1.par_d, bus1.par_p},
                  {4'(n), exp_par(4'(n))});
        end

        // Frame timing at CLKS_PER_BIT=4.
        send4(4'b1010);
        check("tx_start", bus4.tx, 0);
        check("busy_set", bus4.busy, 1);
        wait_done4("done_1010");
        tick();

        // Busy ignore: 0011 offered mid-frame must not disturb anything.
        send4(4'b0110);
        for (int i = 0; i < 4; i++) tick();
        bus4.in_valid = 1'b1;
        bus4.in_data  = 4'b0011;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("busy_ready", bus4.in_ready, 0);
            check("busy_par", {bus4.par_a, bus4.par_b, bus4.par_c, bus4.par_d, bus4.par_p},
                  5'b0110_1);
        end
        bus4.in_valid = 1'b0;
        wait_done4("done_0110");
        tick();
        check("no_accept", bus4.busy, 0);

        // Back-to-back: valid held; second start bit follows the done cycle directly.
        bus4.in_valid = 1'b1;
        bus4.in_data  = 4'b0000;
        q4.push_back(4'b0000);
        tick();
        check("b2b_busy0", bus4.busy, 1);
        check("b2b_p0", bus4.par_p, 1);
        bus4.in_data = 4'b1111;
        q4.push_back(4'b1111);
        wait_done4("done_b2b0");
        tick();
        bus4.in_valid = 1'b0;
        check("b2b_busy1", bus4.busy, 1);
        check("b2b_start1", bus4.tx, 0);
        check("b2b_p1", {bus4.par_a, bus4.par_b, bus4.par_c, bus4.par_d, bus4.par_p},
              5'b1111_1);
        wait_done4("done_b2b1");
        tick();

        // Mid-frame asynchronous reset: outputs return to idle immediately, no done.
        send4(4'b1100);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        q4.delete();
        held = {bus4.tx, bus4.busy, bus4.in_ready, bus4.par_p, bus4.done};
        check("mid_rst", held, 5'b1_0_1_1_0);
        check("mid_rst_par", {bus4.par_a, bus4.par_b, bus4.par_c, bus4.par_d}, 4'b0000);
        tick();
        check("mid_rst_done", bus4.done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("post_rst_done", bus4.done, 0);
        end

        // One more single-cycle-bit frame after reset, then drain.
        send1(4'b1001);
        for (int i = 0; i < 200 && (q4.size() != 0 || q1.size() != 0); i++) tick();
        tick();
        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_odd_parity_serial_tx
